imm_encoder: RTL and testbench

Pipelined RISC-V immediate encoder: the inverse of the core's immediate generator. It takes a base instruction word, an immediate value and an `IMM_t` format selector (I, Iu, S, B, Bu, U, J), and scatters the immediate into that format's bit fields. It checks range and alignment, then returns the finished 32-bit instruction through a valid/ready handshake. It sits between the debug/boot loader and instruction memory, and it is the golden encoder the decoder bench uses to build stimulus.

---
 rtl/imm_encoder.sv | 170 +++++++++++++++++
 tb/tb_imm_encoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Two-stage RISC-V immediate encoder: scatters an immediate into the fields of a
// base instruction word for formats I/Iu/S/B/Bu/U/J, with range and alignment checks.
`timescale 1ns/1ps

package Imm_pkg;
  typedef enum logic [2:0] {
    I  = 3'd0,
    Iu = 3'd1,
    S  = 3'd2,
    B  = 3'd3,
    Bu = 3'd4,
    U  = 3'd5,
    J  = 3'd6
  } IMM_t;
endpackage

module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [1:0]  out_err,
  output logic [7:0]  err_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds its payload stable while valid is high and ready is low.

  logic [31:0] mask_c, fields_c, mask_eff, fields_eff;
  logic        range_bad, align_bad, illegal;
  logic [1:0]  err_c;

  always_comb begin
    mask_c    = '0;
    fields_c  = '0;
    range_bad = 1'b0;
    align_bad = 1'b0;
    illegal   = 1'b0;
    case (Imm_pkg::IMM_t'(in_type))
      Imm_pkg::I: begin
        mask_c    = 32'hFFF0_0000;
        fields_c  = {in_imm[11:0], 20'd0};
        range_bad = !((&in_imm[31:11]) || (~|in_imm[31:11]));
      end
      Imm_pkg::Iu: begin
        mask_c    = 32'hFFF0_0000;
        fields_c  = {in_imm[11:0], 20'd0};
        range_bad = |in_imm[31:12];
      end
      Imm_pkg::S: begin
        mask_c    = 32'hFE00_0F80;
        fields_c  = {in_imm[11:5], 13'd0, in_imm[4:0], 7'd0};
        range_bad = !((&in_imm[31:11]) || (~|in_imm[31:11]));
      end
      Imm_pkg::B: begin
        mask_c    = 32'hFE00_0F80;
        fields_c  = {in_imm[12], in_imm[10:5], 13'd0, in_imm[4:1], in_imm[11], 7'd0};
        range_bad = !((&in_imm[31:12]) || (~|in_imm[31:12]));
        align_bad = in_imm[0];
      end
      Imm_pkg::Bu: begin
        mask_c    = 32'hFE00_0F80;
        fields_c  = {in_imm[12], in_imm[10:5], 13'd0, in_imm[4:1], in_imm[11], 7'd0};
        range_bad = |in_imm[31:13];
        align_bad = in_imm[0];
      end
      Imm_pkg::U: begin
        mask_c    = 32'hFFFF_F000;
        fields_c  = {in_imm[31:12], 12'd0};
        align_bad = |in_imm[11:0];
      end
      Imm_pkg::J: begin
        mask_c    = 32'hFFFF_F000;
        fields_c  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'd0};
        range_bad = !((&in_imm[31:20]) || (~|in_imm[31:20]));
        align_bad = in_imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // Illegal type outranks misalignment, which outranks range.
  assign err_c      = illegal ? 2'd3 : align_bad ? 2'd2 : range_bad ? 2'd1 : 2'd0;
  // A zero mask and zero fields make the merge return the base word untouched.
  assign mask_eff   = (err_c == 2'd0) ? mask_c : '0;
  assign fields_eff = (err_c == 2'd0) ? fields_c : '0;

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_base_q, s1_base_d;
  logic [31:0] s1_mask_q, s1_mask_d;
  logic [31:0] s1_fields_q, s1_fields_d;
  logic [1:0]  s1_err_q, s1_err_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic [1:0]  s2_err_q, s2_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic        s2_load, in_fire, out_fire;

  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_valid_q & out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_base_d   = s1_base_q;
    s1_mask_d   = s1_mask_q;
    s1_fields_d = s1_fields_q;
    s1_err_d    = s1_err_q;
    s2_valid_d  = s2_valid_q;
    s2_instr_d  = s2_instr_q;
    s2_err_d    = s2_err_q;
    err_count_d = err_count_q;
    if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_base_d   = in_base;
      s1_mask_d   = mask_eff;
      s1_fields_d = fields_eff;
      s1_err_d    = err_c;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_instr_d = (s1_base_q & ~s1_mask_q) | s1_fields_q;
      s2_err_d   = s1_err_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
    if (out_fire && (s2_err_q != 2'd0) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_base_q   <= '0;
      s1_mask_q   <= '0;
      s1_fields_q <= '0;
      s1_err_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_instr_q  <= '0;
      s2_err_q    <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_base_q   <= s1_base_d;
      s1_mask_q   <= s1_mask_d;
      s1_fields_q <= s1_fields_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      s2_instr_q  <= s2_instr_d;
      s2_err_q    <= s2_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors with literal results, a format-rule model
// feeding a scoreboard queue, backpressure, saturation and mid-flight reset.
`timescale 1ns/1ps

module tb_imm_encoder;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_type;
  logic [31:0] in_imm, in_base;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [1:0]  out_err;
  logic [7:0]  err_count;

  imm_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_imm(in_imm), .in_base(in_base),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int out_hs   = 0;
  int exp_cnt  = 0;
  logic [33:0] exp_q[$];
  logic [33:0] held;
  logic        held_v = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] place(input logic [2:0] t, input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    case (t)
      3'd0, 3'd1: r[31:20] = v[11:0];
      3'd2: begin r[31:25] = v[11:5]; r[11:7] = v[4:0]; end
      3'd3, 3'd4: begin r[31] = v[12]; r[30:25] = v[10:5]; r[11:8] = v[4:1]; r[7] = v[11]; end
      3'd5: r[31:12] = v[31:12];
      3'd6: begin r[31] = v[20]; r[30:21] = v[10:1]; r[20] = v[11]; r[19:12] = v[19:12]; end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [33:0] model(input logic [2:0] t, input logic [31:0] imm,
                                        input logic [31:0] base);
    longint v, lo, hi;
    logic even, u_al;
    logic [1:0] e;
    logic [31:0] m;
    v = $signed(imm);
    lo = -64'sd2147483648;
    hi = 64'sd2147483647;
    even = 1'b0;
    u_al = 1'b0;
    case (t)
      3'd0: begin lo = -2048;    hi = 2047;    end
      3'd1: begin lo = 0;        hi = 4095;    end
      3'd2: begin lo = -2048;    hi = 2047;    end
      3'd3: begin lo = -4096;    hi = 4094;    even = 1'b1; end
      3'd4: begin lo = 0;        hi = 8190;    even = 1'b1; end
      3'd5: u_al = 1'b1;
      3'd6: begin lo = -1048576; hi = 1048574; even = 1'b1; end
      default: ;
    endcase
    if (t == 3'd7)                                        e = 2'd3;
    else if ((even && imm[0]) || (u_al && imm[11:0] != 0)) e = 2'd2;
    else if (v < lo || v > hi)                            e = 2'd1;
    else                                                  e = 2'd0;
    m = place(t, 32'hFFFF_FFFF);
    if (e != 2'd0) return {e, base};
    return {e, (base & ~m) | place(t, imm)};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst) begin
      chk("err_count", 64'(err_count), 64'(exp_cnt));
      if (held_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_payload", 64'({out_err, out_instr}), 64'(held));
      end
      held_v = out_valid && !out_ready;
      held   = {out_err, out_instr};
      if (in_valid && in_ready) exp_q.push_back(model(in_type, in_imm, in_base));
      if (out_valid && out_ready) begin
        out_hs++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=unexpected_output %0h expected=none", out_instr);
        end else begin
          e = exp_q.pop_front();
          chk("sb_out", 64'({out_err, out_instr}), 64'(e));
          if (e[33:32] != 2'd0 && exp_cnt != 255) exp_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with an empty S1; checks model, latency and literal result.
  task automatic run_vec(input string name, input logic [2:0] t, input logic [31:0] imm,
                         input logic [31:0] base, input logic [31:0] x_instr,
                         input logic [1:0] x_err);
    bit acc;
    chk({"model_", name}, 64'(model(t, imm, base)), 64'({x_err, x_instr}));
    in_type   = t;
    in_imm    = imm;
    in_base   = base;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    chk({"accept_", name}, 64'(acc), 64'd1);
    chk({"lat_early_", name}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({"lat_valid_", name}, 64'(out_valid), 64'd1);
    chk({"instr_", name}, 64'(out_instr), 64'(x_instr));
    chk({"err_", name}, 64'(out_err), 64'(x_err));
  endtask

  task automatic set_req(input logic [2:0] t, input logic [31:0] imm, input logic [31:0] base);
    in_type  = t;
    in_imm   = imm;
    in_base  = base;
    in_valid = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs0, stalls;
    rst = 1'b1; in_valid = 1'b0; in_type = '0; in_imm = '0; in_base = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;

    run_vec("I_m1",   3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'd0);
    run_vec("Iu_4095",3'd1, 32'd4095,      32'h0000_0013, 32'hFFF0_0013, 2'd0);
    run_vec("S_8",    3'd2, 32'd8,         32'h0020_A023, 32'h0020_A423, 2'd0);
    run_vec("B_m4",   3'd3, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 2'd0);
    run_vec("J_2048", 3'd6, 32'd2048,      32'h0000_006F, 32'h0010_006F, 2'd0);
    run_vec("U_ok",   3'd5, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 2'd0);
    run_vec("I_2048", 3'd0, 32'd2048,      32'h0000_0013, 32'h0000_0013, 2'd1);
    run_vec("B_3",    3'd3, 32'd3,         32'h0000_0063, 32'h0000_0063, 2'd2);
    run_vec("U_mis",  3'd5, 32'h1234_5001, 32'h0000_0037, 32'h0000_0037, 2'd2);
    run_vec("ill_7",  3'd7, 32'd0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd3);
    @(posedge clk);
    #1;
    chk("err_count_4", 64'(err_count), 64'd4);

    run_vec("Bu_8190", 3'd4, 32'd8190,      32'h0000_0063, 32'hFE00_0FE3, 2'd0);
    run_vec("I_base",  3'd0, 32'd0,         32'hFFFF_FFFF, 32'h000F_FFFF, 2'd0);
    run_vec("J_max",   3'd6, 32'd1048574,   32'h0000_006F, 32'h7FFF_F06F, 2'd0);
    run_vec("J_min",   3'd6, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 2'd0);
    run_vec("S_m2049", 3'd2, 32'hFFFF_F7FF, 32'h0000_0023, 32'h0000_0023, 2'd1);
    run_vec("Bu_m2",   3'd4, 32'hFFFF_FFFE, 32'h0000_0063, 32'h0000_0063, 2'd1);
    run_vec("J_over",  3'd6, 32'd1048576,   32'h0000_006F, 32'h0000_006F, 2'd1);
    run_vec("Iu_m1",   3'd1, 32'hFFFF_FFFF, 32'h0000_0013, 32'h0000_0013, 2'd1);
    @(posedge clk);
    #1;
    chk("err_count_8", 64'(err_count), 64'd8);
    @(posedge clk);
    #1;

    // Backpressure: three offered, two accepted, then in-order drain.
    out_ready = 1'b0;
    set_req(3'd0, 32'd1, 32'h0000_0013);
    @(negedge clk); chk("bp_ready_a", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    set_req(3'd0, 32'd2, 32'h0000_0013);
    @(negedge clk); chk("bp_ready_b", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    set_req(3'd0, 32'd3, 32'h0000_0013);
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stall_ready", 64'(in_ready), 64'd0);
      chk("bp_stall_instr", 64'(out_instr), 64'h0010_0013);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_a", 64'(out_instr), 64'h0010_0013);
    chk("bp_ready_c", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_valid_b", 64'(out_valid), 64'd1);
    chk("bp_out_b", 64'(out_instr), 64'h0020_0013);
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid_c", 64'(out_valid), 64'd1);
    chk("bp_out_c", 64'(out_instr), 64'h0030_0013);
    repeat (2) @(posedge clk);
    #1;

    // Streaming illegal types: full throughput and counter saturation.
    hs0 = out_hs;
    stalls = 0;
    for (int i = 0; i < 256; i++) begin
      set_req(3'd7, 32'(i), 32'h0000_1000 + 32'(i));
      if (!in_ready) stalls++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_results", 64'(out_hs - hs0), 64'd256);
    @(posedge clk); #1;
    chk("err_count_sat", 64'(err_count), 64'd255);
    @(posedge clk); #1;

    // Reset with both stages full.
    out_ready = 1'b0;
    set_req(3'd0, 32'd5, 32'h0000_0013);
    @(posedge clk); #1;
    set_req(3'd0, 32'd6, 32'h0000_0013);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_ready", 64'(in_ready), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_err_count", 64'(err_count), 64'd0);
    exp_q.delete();
    exp_cnt = 0;
    held_v = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_vec("post_rst", 3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 2'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
